// File: rtl/instr_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl_pkg
// Shared types and constants for the instruction fetch sequencer:
//   INSTR_MEM_SIZE_BYTES : size of the fetchable instruction ROM window
//   IMEM_ADDR_W          : byte-address width of that window
//   fetch_entry_t        : one prefetch buffer entry {pc, instr}
//   fetch_state_t        : fetch sequencer state (RUN / FAULT)
//   fetch_addr_bad()     : fetch legality check for a PC
// -----------------------------------------------------------------------------
package instr_fetch_ctrl_pkg;

    localparam int INSTR_MEM_SIZE_BYTES = 256;
    localparam int IMEM_ADDR_W          = $clog2(INSTR_MEM_SIZE_BYTES);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    // A fetch is illegal when the PC is not word aligned or lies past the ROM.
    function automatic logic fetch_addr_bad(input logic [31:0] pc,
                                            input logic [31:0] mem_bytes);
        return (pc[1:0] != 2'b00) || (pc >= mem_bytes);
    endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl_if
// Bundles the ROM port, the redirect request, the decoder handshake and the
// fault report of the fetch sequencer.
//   master : fetch sequencer side
//   slave  : environment side (ROM, decoder, redirect source)
// Signal suffixes (_i/_o) are given from the fetch sequencer's point of view.
// -----------------------------------------------------------------------------
interface instr_fetch_ctrl_if;

    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;
    logic        redirect_i;
    logic [31:0] redirect_addr_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        fault_o;
    logic [31:0] fault_addr_o;

    modport master (
        output imem_addr_o,
        input  imem_data_i,
        input  redirect_i,
        input  redirect_addr_i,
        output instr_valid_o,
        input  instr_ready_i,
        output instr_o,
        output instr_pc_o,
        output fault_o,
        output fault_addr_o
    );

    modport slave (
        input  imem_addr_o,
        output imem_data_i,
        output redirect_i,
        output redirect_addr_i,
        input  instr_valid_o,
        output instr_ready_i,
        input  instr_o,
        input  instr_pc_o,
        input  fault_o,
        input  fault_addr_o
    );

endinterface

// File: rtl/instr_fetch_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl_fifo
// Synchronous prefetch FIFO of fetch_entry_t.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   i_push       : write i_data at the tail
//   i_pop        : remove the head
//   i_flush      : discard all entries (wins over push/pop)
//   i_data       : entry to write
//   o_head       : entry at the head (storage register, no output mux logic
//                  beyond the read pointer select)
//   o_full       : DEPTH entries held
//   o_empty      : no entries held
// A push while full is accepted only together with a pop in the same cycle.
// -----------------------------------------------------------------------------
module instr_fetch_ctrl_fifo
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    // Qualify requests so the FIFO can never over- or underflow.
    always_comb begin
        w_do_pop  = 1'b0;
        w_do_push = 1'b0;
        if (i_pop && !o_empty) begin
            w_do_pop = 1'b1;
        end else begin
            w_do_pop = 1'b0;
        end
        if (i_push && (!o_full || w_do_pop)) begin
            w_do_push = 1'b1;
        end else begin
            w_do_push = 1'b0;
        end
    end

    // Entry storage; cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// instr_fetch_ctrl
// Fetch sequencer in front of the combinational instruction ROM. Owns the PC,
// drives the ROM address, buffers {pc, instr} pairs in a prefetch FIFO and
// hands them to the decoder over valid/ready. Redirects flush the buffer and
// restart fetching; misaligned or out-of-range PCs raise a sticky fault.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   bus.imem_addr_o       : ROM byte address (current PC)
//   bus.imem_data_i       : ROM read data, combinational from imem_addr_o
//   bus.redirect_i/_addr_i: one-cycle restart request and its target PC
//   bus.instr_valid_o/_ready_i/instr_o/instr_pc_o : decoder handshake
//   bus.fault_o/fault_addr_o : sticky fetch fault and offending PC
// -----------------------------------------------------------------------------
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          MEM_BYTES  = INSTR_MEM_SIZE_BYTES,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    instr_fetch_ctrl_if.master bus
);

    logic [31:0]  r_pc;
    fetch_state_t r_state;
    logic         r_fault;
    logic [31:0]  r_fault_addr;

    logic         w_bad;
    logic         w_pop;
    logic         w_push;
    logic         w_full;
    logic         w_empty;
    fetch_entry_t w_push_entry;
    fetch_entry_t w_head;

    assign w_bad        = fetch_addr_bad(r_pc, 32'(MEM_BYTES));
    assign w_push_entry = '{pc: r_pc, instr: bus.imem_data_i};

    assign bus.imem_addr_o   = r_pc;
    assign bus.instr_valid_o = !w_empty;
    assign bus.instr_o       = w_head.instr;
    assign bus.instr_pc_o    = w_head.pc;
    assign bus.fault_o       = r_fault;
    assign bus.fault_addr_o  = r_fault_addr;

    // Handshake and fetch decision; a full buffer may still accept a word
    // when the head leaves in the same cycle, giving 1 instr/cycle.
    always_comb begin
        w_pop  = 1'b0;
        w_push = 1'b0;
        if (!w_empty && bus.instr_ready_i) begin
            w_pop = 1'b1;
        end else begin
            w_pop = 1'b0;
        end
        if ((r_state == RUN) && !w_bad && !bus.redirect_i && (!w_full || w_pop)) begin
            w_push = 1'b1;
        end else begin
            w_push = 1'b0;
        end
    end

    // PC / fault FSM; redirect has priority and is the only way out of FAULT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pc         <= RESET_PC;
            r_state      <= RUN;
            r_fault      <= 1'b0;
            r_fault_addr <= 32'h0000_0000;
        end else if (bus.redirect_i) begin
            r_pc    <= bus.redirect_addr_i;
            r_state <= RUN;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_bad) begin
                        r_state      <= FAULT;
                        r_fault      <= 1'b1;
                        r_fault_addr <= r_pc;
                    end else if (w_push) begin
                        r_pc <= r_pc + 32'd4;
                    end
                end
                FAULT: begin
                    r_state <= FAULT;
                end
                default: begin
                    r_state <= FAULT;
                    r_fault <= 1'b1;
                end
            endcase
        end
    end

    instr_fetch_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_i),
        .i_data  (w_push_entry),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
module tb_instr_fetch_ctrl;
    import instr_fetch_ctrl_pkg::*;

    localparam logic [31:0] MEMB = 32'(INSTR_MEM_SIZE_BYTES);

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    logic [63:0] sb_q [$];

    instr_fetch_ctrl_if bus ();

    instr_fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .MEM_BYTES  (INSTR_MEM_SIZE_BYTES),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    // ROM contents: word i = (i<<20) | ((i&31)<<7) | 0x13
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        logic [IMEM_ADDR_W-3:0] idx;
        idx = addr[IMEM_ADDR_W-1:2];
        return (32'(idx) << 20) | (32'(idx[4:0]) << 7) | 32'h0000_0013;
    endfunction

    always_comb bus.imem_data_i = rom_word(bus.imem_addr_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic [31:0] pc);
        sb_q.push_back({pc, rom_word(pc)});
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_val(tag, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic pulse_redirect(input logic [31:0] addr);
        bus.redirect_i      = 1'b1;
        bus.redirect_addr_i = addr;
        step(1);
        bus.redirect_i      = 1'b0;
    endtask

    // Scoreboard monitor: each completed transfer must match the queue head.
    always @(negedge clk) begin
        if (!rst && bus.instr_valid_o && bus.instr_ready_i) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected", {bus.instr_pc_o, bus.instr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check_val("sb_transfer", {bus.instr_pc_o, bus.instr_o}, sb_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Release from reset with ready high: first word valid one edge later, no bubbles.
    task automatic scen_startup(input string tag);
        bus.instr_ready_i = 1'b1;
        sb_push(32'h0); sb_push(32'h4); sb_push(32'h8); sb_push(32'hC);
        rst = 1'b0;
        check_val({tag, "_valid_before_edge"}, 64'(bus.instr_valid_o), 64'd0);
        step(1);
        check_val({tag, "_head0"}, {31'd0, bus.instr_valid_o, bus.instr_pc_o}, {31'd0, 1'b1, 32'h0});
        step(1);
        check_val({tag, "_head1"}, {31'd0, bus.instr_valid_o, bus.instr_pc_o}, {31'd0, 1'b1, 32'h4});
        step(1);
        check_val({tag, "_head2"}, {31'd0, bus.instr_valid_o, bus.instr_pc_o}, {31'd0, 1'b1, 32'h8});
        wait_drain({tag, "_drain"});
        bus.instr_ready_i = 1'b0;
    endtask

    initial begin
        n_checks            = 0;
        n_pass              = 0;
        rst                 = 1'b1;
        bus.redirect_i      = 1'b0;
        bus.redirect_addr_i = 32'h0;
        bus.instr_ready_i   = 1'b1;
        step(3);

        // Reset state
        check_val("rst_valid", 64'(bus.instr_valid_o), 64'd0);
        check_val("rst_instr", {bus.instr_pc_o, bus.instr_o}, 64'd0);
        check_val("rst_fault", {31'd0, bus.fault_o, bus.fault_addr_o}, 64'd0);
        check_val("rst_addr", 64'(bus.imem_addr_o), 64'd0);

        // Scenario 1: streaming start-up
        scen_startup("s1");

        // Scenario 2: back-pressure from the first valid
        rst = 1'b1;
        bus.instr_ready_i = 1'b0;
        step(2);
        sb_push(32'h0);
        rst = 1'b0;
        step(1);
        check_val("s2_first", {31'd0, bus.instr_valid_o, bus.instr_pc_o}, {31'd0, 1'b1, 32'h0});
        for (int i = 0; i < 5; i++) begin
            step(1);
            check_val("s2_stall_head", {bus.instr_pc_o, bus.instr_o}, {32'h0, 32'h0000_0013});
            check_val("s2_stall_addr", {31'd0, bus.instr_valid_o, bus.imem_addr_o}, {31'd0, 1'b1, 32'h8});
        end
        bus.instr_ready_i = 1'b1;
        step(1);
        bus.instr_ready_i = 1'b0;
        check_val("s2_fullpop", {bus.instr_pc_o, bus.imem_addr_o}, {32'h4, 32'hC});

        // Scenario 3: redirect discards 0x4/0x8
        pulse_redirect(32'h40);
        check_val("s3_flush", {31'd0, bus.instr_valid_o, bus.imem_addr_o}, {31'd0, 1'b0, 32'h40});
        step(1);
        check_val("s3_head", {31'd0, bus.instr_valid_o, bus.instr_pc_o}, {31'd0, 1'b1, 32'h40});
        sb_push(32'h40); sb_push(32'h44); sb_push(32'h48); sb_push(32'h4C);
        bus.instr_ready_i = 1'b1;
        wait_drain("s3_drain");
        bus.instr_ready_i = 1'b0;

        // Scenario 4: end of ROM, fault with buffered words draining
        pulse_redirect(MEMB - 32'd8);
        sb_push(MEMB - 32'd8); sb_push(MEMB - 32'd4);
        step(2);
        check_val("s4_lastword_ok", {31'd0, bus.fault_o, bus.imem_addr_o}, {31'd0, 1'b0, MEMB});
        step(1);
        check_val("s4_fault", {31'd0, bus.fault_o, bus.fault_addr_o}, {31'd0, 1'b1, MEMB});
        check_val("s4_buffered", {31'd0, bus.instr_valid_o, bus.instr_pc_o}, {31'd0, 1'b1, MEMB - 32'd8});
        bus.instr_ready_i = 1'b1;
        wait_drain("s4_drain");
        step(3);
        check_val("s4_stopped", {31'd0, bus.instr_valid_o, bus.imem_addr_o}, {31'd0, 1'b0, MEMB});
        check_val("s4_sticky", 64'(bus.fault_o), 64'd1);

        // Scenario 5: redirect to a misaligned address, then recover
        pulse_redirect(32'h6);
        check_val("s5_cleared", {31'd0, bus.fault_o, bus.imem_addr_o}, {31'd0, 1'b0, 32'h6});
        step(1);
        check_val("s5_fault", {31'd0, bus.fault_o, bus.fault_addr_o}, {31'd0, 1'b1, 32'h6});
        check_val("s5_novalid", 64'(bus.instr_valid_o), 64'd0);
        sb_push(32'h10); sb_push(32'h14); sb_push(32'h18);
        pulse_redirect(32'h10);
        check_val("s5_recover", 64'(bus.fault_o), 64'd0);
        wait_drain("s5_drain");
        bus.instr_ready_i = 1'b0;

        // Scenario 6: asynchronous reset with a full buffer
        step(3);
        check_val("s6_full_valid", 64'(bus.instr_valid_o), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_val("s6_async_valid", {31'd0, bus.instr_valid_o, bus.imem_addr_o}, 64'd0);
        check_val("s6_async_head", {bus.instr_pc_o, bus.instr_o}, 64'd0);
        step(2);
        scen_startup("s6");

        check_val("sb_final", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
